// File: rtl/imm_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_pkg
// Description : Shared types for the decode-stage immediate pipeline:
//               immediate format codes, skid-buffer states and the widest
//               buffer-entry layout. Holds nothing that depends on XLEN;
//               modules build their exact-width entry types locally.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_decode_pkg;

    // Immediate format codes carried on in_imm_src / out_imm_src.
    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_LOAD = 3'b001,
        IMM_S    = 3'b010,
        IMM_B    = 3'b011,
        IMM_U    = 3'b100,
        IMM_J    = 3'b101,
        IMM_CSR  = 3'b110,
        IMM_ILL  = 3'b111
    } imm_src_e;

    // Occupancy of the two-entry output/skid buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    // Widest supported entry shape (XLEN up to 64, tag up to 8 bits).
    // The stage itself uses a local typedef sized to its own parameters.
    localparam int unsigned IMM_MAX_XLEN  = 64;
    localparam int unsigned IMM_MAX_TAG_W = 8;

    typedef struct packed {
        logic [IMM_MAX_XLEN-1:0]  imm;
        imm_src_e                 src;
        logic [IMM_MAX_TAG_W-1:0] tag;
        logic                     illegal;
    } imm_entry_t;

endpackage : imm_decode_pkg
`default_nettype wire

// File: rtl/imm_extend.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend
// Description : Combinational RV immediate extractor. Maps an instruction
//               word and a format code to a sign/zero-extended XLEN-bit
//               immediate plus an "unsupported format" flag.
// Ports       : instr   (in,  32)   instruction word
//               imm_src (in,  3)    format code (imm_src_e encoding)
//               imm     (out, XLEN) extended immediate, 0 when illegal
//               illegal (out, 1)    format code not supported in this build
// Config      : IMM_DECODE_CSR_EN - when defined, code 110 yields the
//               zero-extended CSR uimm (instr[19:15]); otherwise 110 is
//               handled like 111 (illegal).
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] w_imm32;

    // Opcode bits never contribute to any immediate.
    logic w_unused_opcode;
    assign w_unused_opcode = ^instr[6:0];

    always_comb begin
        w_imm32 = '0;
        illegal = 1'b0;
        imm     = '0;
        case (imm_src_e'(imm_src))
            IMM_I, IMM_LOAD: w_imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:           w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:           w_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                        instr[30:25], instr[11:8], 1'b0};
            IMM_U:           w_imm32 = {instr[31:12], 12'b0};
            IMM_J:           w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                        instr[20], instr[30:21], 1'b0};
`ifdef IMM_DECODE_CSR_EN
            IMM_CSR:         w_imm32 = {27'b0, instr[19:15]};
`endif
            default:         illegal = 1'b1;
        endcase
        // Every format is already extended to 32 bits; bit 31 then fills the
        // upper half for RV64 (zero for the CSR uimm, which has bit 31 clear).
        imm       = {XLEN{w_imm32[31]}};
        imm[31:0] = w_imm32;
    end

endmodule : imm_extend
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage
// Description : Pipelined immediate decoder for the RV decode stage. The
//               immediate is computed combinationally on the input side and
//               stored in a two-entry (output + skid) buffer so in_ready comes
//               straight from a flop. Synchronous flush empties the buffer.
// Ports       : clk, rst (async, active-high)
//               flush                      synchronous discard of all entries
//               in_valid / in_ready        upstream handshake (in_ready is a flop)
//               in_instr, in_imm_src, in_tag
//               out_valid / out_ready      downstream handshake
//               out_imm, out_imm_src, out_tag, out_illegal
// Config      : IMM_DECODE_CSR_EN - enables code 110 (CSR zero-extended uimm);
//               without it code 110 reports illegal like 111.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_imm_src,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       src;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    buf_state_e state_q, state_d;
    entry_t     out_q,   out_d;
    entry_t     skid_q,  skid_d;
    logic       in_ready_q, in_ready_d;

    logic [XLEN-1:0] w_new_imm;
    logic            w_new_illegal;
    entry_t          w_new_entry;
    logic            w_in_fire;
    logic            w_out_fire;

    imm_extend #(
        .XLEN (XLEN)
    ) u_imm_extend (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .imm     (w_new_imm),
        .illegal (w_new_illegal)
    );

    assign w_new_entry = '{imm: w_new_imm, src: in_imm_src, tag: in_tag,
                           illegal: w_new_illegal};

    assign out_valid   = (state_q != BUF_EMPTY);
    assign in_ready    = in_ready_q;
    assign w_in_fire   = in_valid & in_ready_q;
    assign w_out_fire  = out_valid & out_ready;

    assign out_imm     = out_q.imm;
    assign out_imm_src = out_q.src;
    assign out_tag     = out_q.tag;
    assign out_illegal = out_q.illegal;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            BUF_EMPTY: begin
                if (w_in_fire) begin
                    out_d   = w_new_entry;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    out_d   = w_new_entry;
                end else if (w_in_fire) begin
                    // Downstream stalled: park the newcomer behind the head.
                    skid_d  = w_new_entry;
                    state_d = BUF_TWO;
                end else if (w_out_fire) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (w_out_fire) begin
                    out_d   = skid_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        // Flush overrides everything, including a same-cycle acceptance.
        if (flush) begin
            state_d = BUF_EMPTY;
        end
        // Registered ready reflects the occupancy we are about to enter.
        in_ready_d = (state_d != BUF_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

endmodule : imm_decode_stage
`default_nettype wire

// File: doc/imm_decode_stage.md
# imm_decode_stage

- Pipelined, parametrised immediate decoder for the decode stage of the pipelined RV core.
- Accepts the instruction word and format code over a valid/ready handshake.
- Produces the sign- or zero-extended immediate, XLEN bits wide, one cycle later.
- Contains a 2-entry skid buffer so `in_ready` is registered, plus a synchronous flush for branch redirects.
- Covers I, S, B, U and J formats.

## Interface
- `XLEN`, 32, datapath width; legal values 32 or 64.
- `TAG_W`, 5, width of the sideband tag carried alongside the immediate (e.g. rd index).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous flush; discards all held entries.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  registered; high when the skid slot is free.
- `in_instr`  in  32  instruction word.
- `in_imm_src`  in  3  format code.
- `in_tag`  in  TAG_W  sideband tag.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  downstream accept.
- `out_imm`  out  XLEN  extended immediate.
- `out_imm_src`  out  3  format code of the output entry.
- `out_tag`  out  TAG_W  tag of the output entry.
- `out_illegal`  out  1  format code was unsupported; `out_imm` is 0 in that case.

## Operation
- Format codes and immediates (sext/zext to XLEN):
  - 000 I-ALU: `sext(instr[31:20])`
  - 001 I-load: same as 000
  - 010 S: `sext({instr[31:25], instr[11:7]})`
  - 011 B: `sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})`
  - 100 U: `sext({instr[31:12], 12'b0})`; bit 31 replicates when XLEN=64
  - 101 J: `sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})`
  - 110 CSR-uimm: `zext(instr[19:15])`, only when the macro below is set
  - 111: illegal
- Immediate computation is combinational on the input side. The result is stored in the buffer, not the raw instruction.
- Buffer state machine, states EMPTY, ONE and TWO:
  - `in_fire = in_valid & in_ready`
  - `out_fire = out_valid & out_ready`
  - EMPTY: `in_fire` → ONE.
  - ONE: `in_fire & out_fire` → ONE, output register replaced.
  - ONE: `in_fire & !out_fire` → TWO, new entry goes to the skid register.
  - ONE: `!in_fire & out_fire` → EMPTY.
  - TWO: `in_ready = 0`. `out_fire` → ONE, skid entry moves to the output register.
- `out_valid = (state != EMPTY)`. `in_ready = (state != TWO)`, driven from a flop.
- Order is strictly preserved. No entry is dropped or duplicated.
- `flush` → EMPTY next edge, regardless of other inputs. An `in_fire` in the same cycle is discarded.

## Timing
- Latency is 1 cycle from `in_fire` to `out_valid` when starting from EMPTY.
- Sustains 1 entry/cycle while `out_ready` stays high.
- Reset values while `rst` is high:
  - state EMPTY, `in_ready = 1`, `out_valid = 0`
  - `out_imm = 0`, `out_imm_src = 0`, `out_tag = 0`, `out_illegal = 0`
- Reset asserted mid-operation clears both entries immediately, with no clock needed.
- Outputs hold stable while `out_valid & !out_ready`.
- After a flush, `in_ready` is 1 in the following cycle.

## Configuration
- Macro: `IMM_DECODE_CSR_EN`.
- When defined: code 110 decodes the CSR zero-extended uimm, and `out_illegal = 0`.
- When undefined: code 110 is treated as 111, giving `out_imm = 0` and `out_illegal = 1`.

## Structure
- Shared package `imm_decode_pkg` holds:
  - `imm_src_e` enum with members `IMM_I`, `IMM_LOAD`, `IMM_S`, `IMM_B`, `IMM_U`, `IMM_J`, `IMM_CSR`, `IMM_ILL`.
  - `buf_state_e` enum.
  - `imm_entry_t` struct containing imm, src, tag and illegal.
- The package is XLEN-agnostic. The entry struct width is set by a parameterised typedef local to the module.
- One sub-module, `imm_extend`: purely combinational, parameterised by XLEN, maps (instr, imm_src) to (imm, illegal).
- The top level contains only the skid-buffer control and registers.

## Test plan
- XLEN=32, back-to-back inputs with `out_ready = 1`:
  - I `0xFFF00093` → `0xFFFFFFFF`
  - S `0xFE112E23` → `0xFFFFFFFC`
  - B `0xFE000EE3` → `0xFFFFFFFC`
  - U `0x12345037` → `0x12345000`
  - Each appears exactly 1 cycle after acceptance, one per cycle.
- XLEN=64, U `0x80000037` → `out_imm = 0xFFFFFFFF80000000`.
- Hold `out_ready = 0` and push 3 entries:
  - 2 are accepted, then `in_ready` drops.
  - After releasing `out_ready`, the outputs appear in order with tags 1, 2, then 3.
- State TWO, `flush` with `in_valid = 1` in the same cycle:
  - next cycle `out_valid = 0` and `in_ready = 1`
  - the entry offered in the flush cycle never appears.
- Assert `rst` asynchronously while in state ONE: `out_valid` goes to 0 before the next edge and `out_imm` goes to 0.
- Code 110 with `instr[19:15] = 5'b10101`:
  - with `IMM_DECODE_CSR_EN` → `out_imm = 0x15`, `out_illegal = 0`
  - without it → `out_imm = 0`, `out_illegal = 1`
  - code 111 → `out_illegal = 1` in both builds.
